// File: rtl/move_tx.sv
// UART transmitter sending SYNC/MOVE/CHECKSUM packets, 8N1, with a one-entry pending buffer.
// Define MOVE_TX_PARITY_EN for 8E1 framing (PARITY state between DATA and STOP).
module move_tx #(
    parameter int unsigned CLKS_PER_BIT = 564,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       move_avail,
    input  logic [7:0] move,
    output logic       tx_out,
    output logic       busy,
    output logic       tx_done,
    output logic       overflow
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef MOVE_TX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
    logic par_q, par_d;
`endif

    logic [2:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mv_q, mv_d;
    logic [7:0]    csum_q, csum_d;
    logic [7:0]    pend_q, pend_d;
    logic          pvld_q, pvld_d;
    logic          ovf_q, ovf_d;
    logic          done_q, done_d;
    logic          tx_q, tx_d;
    logic          baud_end;
    logic [7:0]    launch_mv;
    logic [7:0]    next_byte;

    assign baud_end  = (baud_q == BAUD_MAX);
    assign launch_mv = pvld_q ? pend_q : move;
    assign next_byte = (idx_q == 2'd0) ? mv_q : csum_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        mv_d    = mv_q;
        csum_d  = csum_q;
        pend_d  = pend_q;
        pvld_d  = pvld_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        tx_d    = tx_q;
`ifdef MOVE_TX_PARITY_EN
        par_d   = par_q;
`endif

        // Pending buffer: in IDLE a held move is launched and the slot refilled by a same-cycle strobe.
        if (state_q == IDLE) begin
            if (pvld_q) begin
                pvld_d = move_avail;
                if (move_avail) pend_d = move;
            end
        end else if (move_avail) begin
            if (!pvld_q) begin
                pend_d = move;
                pvld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                if (pvld_q || move_avail) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shift_d = SYNC_BYTE;
                    idx_d   = 2'd0;
                    mv_d    = launch_mv;
                    csum_d  = SYNC_BYTE ^ launch_mv;
`ifdef MOVE_TX_PARITY_EN
                    par_d   = ^SYNC_BYTE;
`endif
                end
            end
            START: if (baud_end) begin
                state_d = DATA;
                bit_d   = 3'd0;
                tx_d    = shift_q[0];
            end
            DATA: if (baud_end) begin
                if (bit_q == 3'd7) begin
`ifdef MOVE_TX_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 1'b1;
                    shift_d = shift_q >> 1;
                    tx_d    = shift_q[1];
                end
            end
`ifdef MOVE_TX_PARITY_EN
            PARITY: if (baud_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (baud_end) begin
                if (idx_q != 2'd2) begin
                    state_d = START;
                    idx_d   = idx_q + 1'b1;
                    shift_d = next_byte;
                    tx_d    = 1'b0;
`ifdef MOVE_TX_PARITY_EN
                    par_d   = ^next_byte;
`endif
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            mv_q    <= '0;
            csum_q  <= '0;
            pend_q  <= '0;
            pvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
`ifdef MOVE_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            mv_q    <= mv_d;
            csum_q  <= csum_d;
            pend_q  <= pend_d;
            pvld_q  <= pvld_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
`ifdef MOVE_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_out   = tx_q;
    assign tx_done  = done_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) | pvld_q;
endmodule
